axi_sts_snapshot_register: RTL and testbench

//  AXI4-Lite slave exposing a wide status vector (sts_data) as read-only AXI_DATA_WIDTH words.

---
 rtl/axi_sts_snapshot_register.sv | 193 +++++++++++++++++++
 tb/tb_axi_sts_snapshot_register.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sts_snapshot_register.sv
// ============================================================================
// Module : axi_sts_snapshot_register
// AXI4-Lite read-only window onto a wide status vector, with clear-on-read
// strobe and an optional coherent snapshot (macro AXI_STS_SNAPSHOT_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_sts_snapshot_register #(
  parameter int STS_DATA_WIDTH = 1024,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [STS_DATA_WIDTH-1:0] sts_data,
  output logic                      sts_rd_pulse,
  output logic [AXI_ADDR_WIDTH-1:0] sts_rd_idx,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
  localparam int STS_SIZE = STS_DATA_WIDTH / AXI_DATA_WIDTH;
  localparam int IDX_W    = (STS_SIZE > 1) ? $clog2(STS_SIZE) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] C_STS_SIZE = AXI_ADDR_WIDTH'(STS_SIZE);
  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic                      live_q;
  logic                      aw_hold_q, aw_hold_d;
  logic                      w_hold_q, w_hold_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;

  logic                      aw_hs, w_hs, ar_hs;
  logic                      in_range;
  logic [IDX_W-1:0]          word_sel;
  logic [AXI_DATA_WIDTH-1:0] sel_word;
  logic [AXI_DATA_WIDTH-1:0] live_word [STS_SIZE];
  logic                      unused_inputs;

  for (genvar k = 0; k < STS_SIZE; k++) begin : g_live_words
    assign live_word[k] = sts_data[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  end

`ifdef AXI_STS_SNAPSHOT_EN
  logic [STS_DATA_WIDTH-1:0] snap_q, snap_d;
  logic [AXI_DATA_WIDTH-1:0] snap_word [STS_SIZE];

  for (genvar k = 0; k < STS_SIZE; k++) begin : g_snap_words
    assign snap_word[k] = snap_q[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  end
`endif

  // Write data is never stored; only the handshake matters.
  assign unused_inputs = ^{s_axi_awaddr, s_axi_wdata};

  assign in_range = (idx_q < C_STS_SIZE);
  assign word_sel = idx_q[IDX_W-1:0];
  assign aw_hs    = s_axi_awvalid & s_axi_awready;
  assign w_hs     = s_axi_wvalid & s_axi_wready;
  assign ar_hs    = s_axi_arvalid & s_axi_arready;

  always_comb begin
`ifdef AXI_STS_SNAPSHOT_EN
    // Word 0 always comes live; the read that fetches it also refreshes snap.
    sel_word = (idx_q == '0) ? live_word[word_sel] : snap_word[word_sel];
`else
    sel_word = live_word[word_sel];
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live_q    <= 1'b0;
      aw_hold_q <= 1'b0;
      w_hold_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
`ifdef AXI_STS_SNAPSHOT_EN
      snap_q    <= '0;
`endif
    end else begin
      live_q    <= 1'b1;
      aw_hold_q <= aw_hold_d;
      w_hold_q  <= w_hold_d;
      bvalid_q  <= bvalid_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
`ifdef AXI_STS_SNAPSHOT_EN
      snap_q    <= snap_d;
`endif
    end
  end

  always_comb begin
    aw_hold_d = aw_hold_q;
    w_hold_d  = w_hold_q;
    bvalid_d  = bvalid_q;
    if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end
    // A handshake in this cycle counts as held, so AW+W together respond next cycle.
    if ((aw_hold_q || aw_hs) && (w_hold_q || w_hs)) begin
      bvalid_d  = 1'b1;
      aw_hold_d = 1'b0;
      w_hold_d  = 1'b0;
    end else begin
      if (aw_hs) aw_hold_d = 1'b1;
      if (w_hs)  w_hold_d  = 1'b1;
    end
  end

  assign s_axi_awready = live_q & ~aw_hold_q & ~bvalid_q;
  assign s_axi_wready  = live_q & ~w_hold_q & ~bvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bvalid_q ? C_RESP_SLVERR : C_RESP_OKAY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ar_hs) state_d = S_ADDR;
      S_ADDR:  state_d = S_DATA;
      S_DATA:  if (s_axi_rready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = live_q && (state_q == S_IDLE);
    s_axi_rvalid  = (state_q == S_DATA);
    sts_rd_pulse  = (state_q == S_ADDR) && in_range;
    sts_rd_idx    = sts_rd_pulse ? idx_q : '0;
  end

  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;

  always_comb begin
    idx_d   = idx_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
`ifdef AXI_STS_SNAPSHOT_EN
    snap_d  = snap_q;
`endif
    if (ar_hs) begin
      idx_d = s_axi_araddr >> ADDR_LSB;
    end
    // sts_data is sampled only here, once per read.
    if (state_q == S_ADDR) begin
      if (in_range) begin
        rdata_d = sel_word;
        rresp_d = C_RESP_OKAY;
`ifdef AXI_STS_SNAPSHOT_EN
        if (idx_q == '0) snap_d = sts_data;
`endif
      end else begin
        rdata_d = '0;
        rresp_d = C_RESP_SLVERR;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_sts_snapshot_register.sv
// ============================================================================
// Module : tb_axi_sts_snapshot_register
// Directed self-checking bench for axi_sts_snapshot_register (32-bit, 1024-bit vector).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_sts_snapshot_register;

  localparam int STS_W  = 1024;
  localparam int AXI_W  = 32;
  localparam int ADDR_W = 16;
  localparam int SIZE   = STS_W / AXI_W;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [STS_W-1:0]  sts_data;
  logic              sts_rd_pulse;
  logic [ADDR_W-1:0] sts_rd_idx;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [AXI_W-1:0]  s_axi_wdata;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [AXI_W-1:0]  s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  int checks   = 0;
  int failures = 0;
  int pulse_count = 0;
  logic [STS_W-1:0] tb_snap = '0;

  axi_sts_snapshot_register #(
    .STS_DATA_WIDTH(STS_W),
    .AXI_DATA_WIDTH(AXI_W),
    .AXI_ADDR_WIDTH(ADDR_W)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .sts_data      (sts_data),
    .sts_rd_pulse  (sts_rd_pulse),
    .sts_rd_idx    (sts_rd_idx),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (sts_rd_pulse === 1'b1) pulse_count++;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [AXI_W-1:0] v);
    sts_data[k*AXI_W +: AXI_W] = v;
  endtask

  // Expected read data for word idx given the current vector and bench snapshot.
  function automatic logic [AXI_W-1:0] exp_word(input int idx);
    if (idx >= SIZE) return '0;
`ifdef AXI_STS_SNAPSHOT_EN
    if (idx == 0) return sts_data[AXI_W-1:0];
    return tb_snap[idx*AXI_W +: AXI_W];
`else
    return sts_data[idx*AXI_W +: AXI_W];
`endif
  endfunction

  task automatic read_txn(input logic [ADDR_W-1:0] addr, output logic [AXI_W-1:0] data,
                          output logic [1:0] resp, output logic rv_n1, output logic rv_n2,
                          output logic pulse_n1, output logic [ADDR_W-1:0] idx_n1);
    int n;
    data = 'x; resp = 'x; rv_n1 = 1'bx; rv_n2 = 1'bx; pulse_n1 = 1'bx; idx_n1 = 'x;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (s_axi_arready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL ar_timeout: arready never high for addr %h", addr);
      s_axi_arvalid = 1'b0;
      return;
    end
    tick();
    s_axi_arvalid = 1'b0;
    rv_n1    = s_axi_rvalid;
    pulse_n1 = sts_rd_pulse;
    idx_n1   = sts_rd_idx;
    if ((addr >> 2) == 0) tb_snap = sts_data;
    tick();
    rv_n2 = s_axi_rvalid;
    n = 0;
    while (s_axi_rvalid !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL r_timeout: rvalid never high for addr %h", addr);
      return;
    end
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick(); tick();
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_rvalid, s_axi_bvalid, sts_rd_pulse} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_rvalid, s_axi_bvalid, sts_rd_pulse});
    end
    checks++;
    if ({s_axi_rdata, s_axi_rresp, s_axi_bresp, sts_rd_idx} !== '0) begin
      failures++;
      $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b idx=%h expected all zero",
               s_axi_rdata, s_axi_rresp, s_axi_bresp, sts_rd_idx);
    end
    aresetn = 1'b1;
    tick(); tick();
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_read_word();
    logic [AXI_W-1:0] d, e;
    logic [1:0] r;
    logic v1, v2, p1;
    logic [ADDR_W-1:0] i1;
    int p0;
    set_word(0, 32'hA5A5_0000);
    set_word(3, 32'hDEAD_BEEF);
    set_word(31, 32'hCAFE_F00D);
    e  = exp_word(3);
    p0 = pulse_count;
    read_txn(16'h000C, d, r, v1, v2, p1, i1);
    checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL rd_lat_n1: rvalid=%b expected 0", v1); end
    checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL rd_lat_n2: rvalid=%b expected 1", v2); end
    checks++; if (p1 !== 1'b1 || i1 !== 16'd3) begin
      failures++; $display("FAIL rd_pulse: pulse=%b idx=%h expected 1/0003", p1, i1); end
    checks++; if (d !== e || r !== 2'b00) begin
      failures++; $display("FAIL rd_word3: data=%h resp=%b expected %h/00", d, r, e); end
    checks++; if (pulse_count - p0 !== 1) begin
      failures++; $display("FAIL rd_pulse_cnt: got %0d expected 1", pulse_count - p0); end
    e = exp_word(3);
    read_txn(16'h000F, d, r, v1, v2, p1, i1);
    checks++; if (d !== e || r !== 2'b00 || i1 !== 16'd3) begin
      failures++; $display("FAIL rd_lowbits: data=%h resp=%b idx=%h expected %h/00/0003", d, r, i1, e); end
    e = exp_word(31);
    read_txn(16'h007C, d, r, v1, v2, p1, i1);
    checks++; if (d !== e || r !== 2'b00 || p1 !== 1'b1 || i1 !== 16'd31) begin
      failures++; $display("FAIL rd_last: data=%h resp=%b pulse=%b idx=%h expected %h/00/1/001f", d, r, p1, i1, e); end
  endtask

  task automatic test_out_of_range();
    logic [AXI_W-1:0] d;
    logic [1:0] r;
    logic v1, v2, p1;
    logic [ADDR_W-1:0] i1;
    int p0;
    p0 = pulse_count;
    read_txn(16'h0080, d, r, v1, v2, p1, i1);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin
      failures++; $display("FAIL oor_0x80: data=%h resp=%b expected 00000000/10", d, r); end
    read_txn(16'hFFFC, d, r, v1, v2, p1, i1);
    checks++; if (d !== 32'h0 || r !== 2'b10 || v2 !== 1'b1) begin
      failures++; $display("FAIL oor_top: data=%h resp=%b rvalid_n2=%b expected 00000000/10/1", d, r, v2); end
    checks++; if (pulse_count - p0 !== 0) begin
      failures++; $display("FAIL oor_pulse: got %0d pulses expected 0", pulse_count - p0); end
  endtask

  task automatic test_write();
    logic [AXI_W-1:0] d, e;
    logic [1:0] r;
    logic v1, v2, p1;
    logic [ADDR_W-1:0] i1;
    int bcnt;
    set_word(1, 32'h5555_AAAA);
    s_axi_awaddr = 16'h0004; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    checks++; if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b010) begin
      failures++; $display("FAIL wr_aw_only: aw/w/b=%b expected 010", {s_axi_awready, s_axi_wready, s_axi_bvalid}); end
    tick();
    s_axi_wdata = 32'h0000_1234; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b10) begin
      failures++; $display("FAIL wr_bresp: bvalid=%b bresp=%b expected 1/10", s_axi_bvalid, s_axi_bresp); end
    tick(); tick();
    checks++; if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b100) begin
      failures++; $display("FAIL wr_bhold: b/aw/w=%b expected 100", {s_axi_bvalid, s_axi_awready, s_axi_wready}); end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    bcnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (s_axi_bvalid !== 1'b0) bcnt++;
      tick();
    end
    checks++; if (bcnt !== 0 || {s_axi_awready, s_axi_wready} !== 2'b11) begin
      failures++; $display("FAIL wr_single_b: extra bvalid cycles=%0d readies=%b expected 0/11",
                           bcnt, {s_axi_awready, s_axi_wready}); end
    // AW and W together respond on the very next cycle.
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b10) begin
      failures++; $display("FAIL wr_same_cycle: bvalid=%b bresp=%b expected 1/10", s_axi_bvalid, s_axi_bresp); end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    e = exp_word(1);
    read_txn(16'h0004, d, r, v1, v2, p1, i1);
    checks++; if (d !== e || r !== 2'b00) begin
      failures++; $display("FAIL wr_readback: data=%h resp=%b expected %h/00", d, r, e); end
  endtask

  task automatic test_back_to_back();
    logic [AXI_W-1:0] e;
    int p0, rv_cnt, bad;
    set_word(2, 32'h2222_2222);
    e  = exp_word(2);
    p0 = pulse_count;
    rv_cnt = 0; bad = 0;
    s_axi_rready = 1'b1;
    s_axi_araddr = 16'h0008; s_axi_arvalid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (s_axi_rvalid === 1'b1) begin
        rv_cnt++;
        if (s_axi_rdata !== e) bad++;
      end
    end
    s_axi_arvalid = 1'b0;
    tick();
    s_axi_rready = 1'b0;
    checks++; if (rv_cnt !== 4 || bad !== 0) begin
      failures++; $display("FAIL b2b_rate: rvalid cycles=%0d bad data=%0d expected 4/0", rv_cnt, bad); end
    checks++; if (pulse_count - p0 !== 4) begin
      failures++; $display("FAIL b2b_pulses: got %0d expected 4", pulse_count - p0); end
  endtask

  task automatic test_stall();
    logic [AXI_W-1:0] e;
    set_word(2, 32'h2B2B_2B2B);
    e = exp_word(2);
    s_axi_araddr = 16'h0008; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      set_word(2, 32'hBAD0_0000 + k);
      tick();
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== e || s_axi_arready !== 1'b0) begin
        failures++;
        $display("FAIL stall_%0d: rvalid=%b rdata=%h arready=%b expected 1/%h/0",
                 k, s_axi_rvalid, s_axi_rdata, s_axi_arready, e);
      end
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    checks++; if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      failures++; $display("FAIL stall_release: rvalid=%b arready=%b expected 0/1", s_axi_rvalid, s_axi_arready); end
  endtask

  task automatic test_snapshot();
    logic [AXI_W-1:0] d;
    logic [1:0] r;
    logic v1, v2, p1;
    logic [ADDR_W-1:0] i1;
    set_word(0, 32'h0000_0A0A);
    set_word(1, 32'h0000_0011);
    read_txn(16'h0000, d, r, v1, v2, p1, i1);
    checks++; if (d !== 32'h0000_0A0A || r !== 2'b00) begin
      failures++; $display("FAIL snap_word0: data=%h resp=%b expected 00000a0a/00", d, r); end
    set_word(1, 32'h0000_0022);
    read_txn(16'h0004, d, r, v1, v2, p1, i1);
    checks++;
`ifdef AXI_STS_SNAPSHOT_EN
    if (d !== 32'h0000_0011) begin
      failures++; $display("FAIL snap_word1: data=%h expected 00000011", d); end
`else
    if (d !== 32'h0000_0022) begin
      failures++; $display("FAIL snap_word1: data=%h expected 00000022", d); end
`endif
  endtask

  task automatic test_reset_midflight();
    logic [AXI_W-1:0] d, e;
    logic [1:0] r;
    logic v1, v2, p1;
    logic [ADDR_W-1:0] i1;
    set_word(3, 32'h3333_0003);
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 16'h000C; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    checks++; if ({sts_rd_pulse, s_axi_bvalid} !== 2'b11) begin
      failures++; $display("FAIL rst_pre: pulse/bvalid=%b expected 11", {sts_rd_pulse, s_axi_bvalid}); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if ({s_axi_rvalid, s_axi_bvalid, sts_rd_pulse, s_axi_arready} !== 4'b0) begin
      failures++; $display("FAIL rst_addr: rvalid/bvalid/pulse/arready=%b expected 0000",
                           {s_axi_rvalid, s_axi_bvalid, sts_rd_pulse, s_axi_arready}); end
    tick();
    aresetn = 1'b1;
    tb_snap = '0;
    tick();
    e = exp_word(3);
    read_txn(16'h000C, d, r, v1, v2, p1, i1);
    checks++; if (d !== e || r !== 2'b00 || v2 !== 1'b1) begin
      failures++; $display("FAIL rst_addr_recover: data=%h resp=%b rvalid_n2=%b expected %h/00/1", d, r, v2, e); end
    s_axi_araddr = 16'h000C; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    #2 aresetn = 1'b0;
    #1;
    checks++; if (s_axi_rvalid !== 1'b0 || s_axi_rdata !== 32'h0) begin
      failures++; $display("FAIL rst_data: rvalid=%b rdata=%h expected 0/00000000", s_axi_rvalid, s_axi_rdata); end
    tick();
    aresetn = 1'b1;
    tb_snap = '0;
    tick();
    e = exp_word(0);
    read_txn(16'h0000, d, r, v1, v2, p1, i1);
    checks++; if (d !== e || r !== 2'b00 || p1 !== 1'b1) begin
      failures++; $display("FAIL rst_data_recover: data=%h resp=%b pulse=%b expected %h/00/1", d, r, p1, e); end
  endtask

  initial begin
    aresetn       = 1'b0;
    sts_data      = '0;
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    #1;
    test_reset();
    test_read_word();
    test_out_of_range();
    test_write();
    test_back_to_back();
    test_stall();
    test_snapshot();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
